// File: rtl/multicycle_ctrl_if.sv
// Sequencer <-> datapath/memory signal bundle; master = sequencer side, slave = datapath and memory side.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic        mem_req;
  logic        mem_we;
  logic        mem_is_fetch;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wb_sel;
  logic        reg_write;
  logic [2:0]  imm_type;
  logic [2:0]  state;
  logic        illegal;
  logic        bus_error;

  modport master (
    input  instr, mem_ready, branch_taken,
    output ir_write, pc_write, pc_sel, mem_req, mem_we, mem_is_fetch,
           alu_a_sel, alu_b_sel, alu_ctrl, wb_sel, reg_write, imm_type,
           state, illegal, bus_error
  );

  modport slave (
    output instr, mem_ready, branch_taken,
    input  ir_write, pc_write, pc_sel, mem_req, mem_we, mem_is_fetch,
           alu_a_sel, alu_b_sel, alu_ctrl, wb_sel, reg_write, imm_type,
           state, illegal, bus_error
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle sequencer: 3-5 cycles per instruction plus memory waits; stalls in FETCH/MEM until mem_ready, ERROR after MEM_TIMEOUT unanswered cycles.
// Optional RETIRE_COUNT_EN adds the 64-bit instret counter port.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
`ifdef RETIRE_COUNT_EN
  output logic [63:0] instret,
`endif
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'b000,
    S_DECODE  = 3'b001,
    S_EXECUTE = 3'b010,
    S_MEM     = 3'b011,
    S_WB      = 3'b100,
    S_ERROR   = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
  } iclass_t;

  state_t      r_state, w_next;
  iclass_t     r_class, w_dec_class;
  logic [7:0]  r_cnt;
  logic [2:0]  r_imm_type, w_dec_imm;
  logic [3:0]  r_alu_ctrl, w_dec_alu;
  logic        r_illegal, r_bus_error;
  logic        w_dec_legal, w_timeout, w_limit;
  logic [2:0]  w_f3;

  logic        w_ir_write, w_pc_write, w_mem_req, w_mem_we, w_mem_is_fetch;
  logic        w_alu_b_sel, w_reg_write;
  logic [1:0]  w_pc_sel, w_alu_a_sel, w_wb_sel;
  logic [3:0]  w_alu_ctrl;
  logic        w_unused_instr;

  assign w_f3           = bus.instr[14:12];
  assign w_unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
  assign w_limit        = (r_cnt == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    w_dec_class = C_OP;
    w_dec_imm   = 3'b111;
    w_dec_alu   = 4'b0000;
    w_dec_legal = 1'b1;
    case (bus.instr[6:0])
      7'b0110011: begin w_dec_class = C_OP;     w_dec_imm = 3'b111; w_dec_alu = {bus.instr[30], w_f3}; end
      7'b0010011: begin
        w_dec_class = C_OPIMM;
        w_dec_imm   = 3'b000;
        // only the shift-right encoding uses bit 30 to select arithmetic
        w_dec_alu   = {(w_f3 == 3'b101) & bus.instr[30], w_f3};
      end
      7'b0000011: begin w_dec_class = C_LOAD;   w_dec_imm = 3'b000; end
      7'b1100111: begin w_dec_class = C_JALR;   w_dec_imm = 3'b000; end
      7'b0100011: begin w_dec_class = C_STORE;  w_dec_imm = 3'b001; end
      7'b1100011: begin w_dec_class = C_BRANCH; w_dec_imm = 3'b010; end
      7'b0110111: begin w_dec_class = C_LUI;    w_dec_imm = 3'b011; end
      7'b0010111: begin w_dec_class = C_AUIPC;  w_dec_imm = 3'b011; end
      7'b1101111: begin w_dec_class = C_JAL;    w_dec_imm = 3'b100; end
      default:    w_dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next         = r_state;
    w_timeout      = 1'b0;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_pc_sel       = 2'b00;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_is_fetch = 1'b0;
    w_alu_a_sel    = 2'b00;
    w_alu_b_sel    = 1'b0;
    w_alu_ctrl     = 4'b0000;
    w_wb_sel       = 2'b00;
    w_reg_write    = 1'b0;
    // outputs are forced quiet while reset is held
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          w_mem_req      = 1'b1;
          w_mem_is_fetch = 1'b1;
          if (bus.mem_ready) begin
            w_ir_write = 1'b1;
            w_next     = S_DECODE;
          end else if (w_limit) begin
            w_timeout = 1'b1;
            w_next    = S_ERROR;
          end
        end
        S_DECODE: w_next = w_dec_legal ? S_EXECUTE : S_ERROR;
        S_EXECUTE: begin
          w_alu_ctrl = r_alu_ctrl;
          case (r_class)
            C_OP:    w_next = S_WB;
            C_OPIMM: begin w_alu_b_sel = 1'b1; w_next = S_WB; end
            C_LUI:   begin w_alu_a_sel = 2'b10; w_alu_b_sel = 1'b1; w_next = S_WB; end
            C_AUIPC: begin w_alu_a_sel = 2'b01; w_alu_b_sel = 1'b1; w_next = S_WB; end
            C_LOAD, C_STORE: begin w_alu_b_sel = 1'b1; w_next = S_MEM; end
            C_BRANCH: begin
              w_pc_write = 1'b1;
              w_pc_sel   = bus.branch_taken ? 2'b01 : 2'b00;
              w_next     = S_FETCH;
            end
            C_JAL: begin
              w_pc_write  = 1'b1;
              w_pc_sel    = 2'b01;
              w_reg_write = 1'b1;
              w_wb_sel    = 2'b10;
              w_next      = S_FETCH;
            end
            C_JALR: begin
              w_alu_b_sel = 1'b1;
              w_pc_write  = 1'b1;
              w_pc_sel    = 2'b10;
              w_reg_write = 1'b1;
              w_wb_sel    = 2'b10;
              w_next      = S_FETCH;
            end
            default: w_next = S_ERROR;
          endcase
        end
        S_MEM: begin
          w_mem_req   = 1'b1;
          w_mem_we    = (r_class == C_STORE);
          w_alu_b_sel = 1'b1;
          w_alu_ctrl  = r_alu_ctrl;
          if (bus.mem_ready) begin
            w_pc_write = (r_class == C_STORE);
            w_next     = (r_class == C_STORE) ? S_FETCH : S_WB;
          end else if (w_limit) begin
            w_timeout = 1'b1;
            w_next    = S_ERROR;
          end
        end
        S_WB: begin
          w_reg_write = 1'b1;
          w_wb_sel    = (r_class == C_LOAD) ? 2'b01 : 2'b00;
          w_pc_write  = 1'b1;
          w_next      = S_FETCH;
        end
        S_ERROR: w_next = S_ERROR;
        default: w_next = S_ERROR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_cnt       <= 8'd0;
      r_class     <= C_OP;
      r_imm_type  <= 3'b111;
      r_alu_ctrl  <= 4'b0000;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next;
      // counter runs only while a request stays pending; any state entry clears it
      if ((r_state == S_FETCH || r_state == S_MEM) && w_next == r_state)
        r_cnt <= r_cnt + 8'd1;
      else
        r_cnt <= 8'd0;
      if (r_state == S_DECODE) begin
        r_class    <= w_dec_class;
        r_imm_type <= w_dec_imm;
        r_alu_ctrl <= w_dec_alu;
        if (!w_dec_legal) r_illegal <= 1'b1;
      end
      if (w_timeout) r_bus_error <= 1'b1;
    end
  end

`ifdef RETIRE_COUNT_EN
  logic [63:0] r_instret;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_instret <= 64'd0;
    else if (w_pc_write) r_instret <= r_instret + 64'd1;
  end
  assign instret = r_instret;
`endif

  assign bus.ir_write     = w_ir_write;
  assign bus.pc_write     = w_pc_write;
  assign bus.pc_sel       = w_pc_sel;
  assign bus.mem_req      = w_mem_req;
  assign bus.mem_we       = w_mem_we;
  assign bus.mem_is_fetch = w_mem_is_fetch;
  assign bus.alu_a_sel    = w_alu_a_sel;
  assign bus.alu_b_sel    = w_alu_b_sel;
  assign bus.alu_ctrl     = w_alu_ctrl;
  assign bus.wb_sel       = w_wb_sel;
  assign bus.reg_write    = w_reg_write;
  assign bus.imm_type     = r_imm_type;
  assign bus.state        = r_state;
  assign bus.illegal      = r_illegal;
  assign bus.bus_error    = r_bus_error;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboarded random test of multicycle_ctrl: driver queues expected retire/error/memory events, monitor checks them as the DUT produces them.
module tb_multicycle_ctrl;
  localparam int TO = 15;
  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111,
                         OPC_AUIPC = 7'b0010111, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                         OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;

  typedef struct packed {
    logic        err;
    logic        ill;
    logic        berr;
    logic [1:0]  pc_sel;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  imm;
    logic [1:0]  a;
    logic        b;
    logic [3:0]  ctrl;
    logic [15:0] lat;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
`ifdef RETIRE_COUNT_EN
  logic [63:0] instret;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
`ifdef RETIRE_COUNT_EN
    .instret(instret),
`endif
    .bus(bus)
  );

  ev_t        exp_q[$];
  ev_t        msk_q[$];
  logic [1:0] mem_q[$];   // {is_fetch, we} per expected memory handshake
  int n_checks = 0;
  int n_errors = 0;
  int mon_cyc = 0;
  int ret_cnt = 0;
  logic mon_in_err = 1'b0;
  logic [1:0] ex_a = 2'b00;
  logic       ex_b = 1'b0;
  logic [3:0] ex_ctrl = 4'b0000;

  function automatic void model(input logic [31:0] ins, input logic bt, input int fw, input int mw,
                                output ev_t e, output ev_t m, output int kind);
    logic [2:0] f3;
    int lat;
    f3 = ins[14:12];
    e = '0; m = '1; kind = 0; lat = 4;
    case (ins[6:0])
      OPC_OP:    begin e.reg_write = 1; e.imm = 3'b111; e.ctrl = {ins[30], f3}; end
      OPC_OPIMM: begin e.reg_write = 1; e.imm = 3'b000; e.b = 1; e.ctrl = {(f3 == 3'b101) ? ins[30] : 1'b0, f3}; end
      OPC_LUI:   begin e.reg_write = 1; e.imm = 3'b011; e.a = 2'b10; e.b = 1; end
      OPC_AUIPC: begin e.reg_write = 1; e.imm = 3'b011; e.a = 2'b01; e.b = 1; end
      OPC_LOAD:  begin kind = 1; lat = 5 + mw; e.reg_write = 1; e.wb_sel = 2'b01; e.b = 1; end
      OPC_STORE: begin kind = 2; lat = 4 + mw; e.imm = 3'b001; e.b = 1; m.wb_sel = '0; end
      OPC_BRANCH: begin
        kind = 4; lat = 3; e.imm = 3'b010; e.pc_sel = bt ? 2'b01 : 2'b00;
        m.wb_sel = '0; m.a = '0; m.b = '0; m.ctrl = '0;
      end
      OPC_JAL: begin
        kind = 4; lat = 3; e.imm = 3'b100; e.pc_sel = 2'b01; e.reg_write = 1; e.wb_sel = 2'b10;
        m.a = '0; m.b = '0; m.ctrl = '0;
      end
      OPC_JALR: begin kind = 4; lat = 3; e.b = 1; e.pc_sel = 2'b10; e.reg_write = 1; e.wb_sel = 2'b10; end
      default:  begin kind = 3; lat = 3; e.err = 1; e.ill = 1; end
    endcase
    e.lat = 16'(lat + fw);
  endfunction

  function automatic logic [6:0] pick_opc(input int idx);
    case (idx % 20)
      0, 9:    return OPC_OP;
      1, 10:   return OPC_OPIMM;
      2, 11:   return OPC_LUI;
      3, 12:   return OPC_AUIPC;
      4, 13:   return OPC_LOAD;
      5, 14:   return OPC_STORE;
      6, 15:   return OPC_BRANCH;
      7, 16:   return OPC_JAL;
      8, 17:   return OPC_JALR;
      18:      return 7'b0001111;
      default: return 7'b1110011;
    endcase
  endfunction

  task automatic fail_line(input string nm, input string detail);
    n_errors++;
    $display("FAIL %s: %s", nm, detail);
  endtask

  task automatic sb_check(input ev_t act, input string nm);
    ev_t e, m;
    n_checks++;
    if (exp_q.size() == 0) begin
      fail_line(nm, $sformatf("got event %h, none expected", act));
      return;
    end
    e = exp_q.pop_front();
    m = msk_q.pop_front();
    if ((act & m) != (e & m))
      fail_line(nm, $sformatf("got %h required %h (mask %h)", act & m, e & m, m));
  endtask

  task automatic step(input logic rdy);
    bus.mem_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic noise_step();
    step(1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    logic [24:0] got;
    rst = 1'b1;
    #2;
    got = {bus.state, bus.imm_type, bus.illegal, bus.bus_error, bus.ir_write, bus.pc_write, bus.pc_sel,
           bus.mem_req, bus.mem_we, bus.mem_is_fetch, bus.alu_a_sel, bus.alu_b_sel, bus.alu_ctrl,
           bus.wb_sel, bus.reg_write};
    n_checks++;
    if (got != {3'b000, 3'b111, 19'd0})
      fail_line("reset_outputs", $sformatf("got %h required %h", got, {3'b000, 3'b111, 19'd0}));
`ifdef RETIRE_COUNT_EN
    n_checks++;
    if (instret != 64'd0) fail_line("reset_instret", $sformatf("got %0d required 0", instret));
`endif
    exp_q.delete(); msk_q.delete(); mem_q.delete();
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic bt, input int fw, input int mw, output int kind);
    ev_t e, m;
    model(ins, bt, fw, mw, e, m, kind);
    exp_q.push_back(e); msk_q.push_back(m);
    mem_q.push_back(2'b10);
    if (kind == 1) mem_q.push_back(2'b00);
    if (kind == 2) mem_q.push_back(2'b01);
    repeat (fw) step(1'b0);
    bus.instr = ins; bus.branch_taken = bt;
    step(1'b1);
    noise_step();
    if (kind == 3) begin
      repeat (4) noise_step();
      return;
    end
    noise_step();
    if (kind == 1 || kind == 2) begin
      repeat (mw) step(1'b0);
      step(1'b1);
    end
    if (kind == 0 || kind == 1) noise_step();
  endtask

  task automatic run_timeout(input logic [31:0] ins, input int fw, input logic in_mem);
    ev_t e, m;
    e = '0; m = '1; e.err = 1; e.berr = 1;
    e.lat = in_mem ? 16'(fw + 4 + TO) : 16'(TO + 1);
    exp_q.push_back(e); msk_q.push_back(m);
    mem_q.push_back(2'b10);
    if (in_mem) begin
      mem_q.push_back({1'b0, ins[6:0] == OPC_STORE});
      repeat (fw) step(1'b0);
      bus.instr = ins;
      step(1'b1);
      noise_step(); noise_step();
    end
    repeat (TO) step(1'b0);
    repeat (4) noise_step();
  endtask

  initial begin : monitor
    ev_t act;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_cyc = 0; mon_in_err = 1'b0; ret_cnt = 0;
        continue;
      end
      mon_cyc++;
      if (bus.state == 3'b010) begin
        ex_a = bus.alu_a_sel; ex_b = bus.alu_b_sel; ex_ctrl = bus.alu_ctrl;
      end
      if (bus.mem_req) begin
        n_checks++;
        if (mem_q.size() == 0)
          fail_line("mem_req", "request seen with none expected");
        else begin
          if ({bus.mem_is_fetch, bus.mem_we} != mem_q[0])
            fail_line("mem_kind", $sformatf("got {fetch,we}=%b required %b", {bus.mem_is_fetch, bus.mem_we}, mem_q[0]));
          if (bus.mem_ready) begin
            n_checks++;
            if (bus.ir_write != mem_q[0][1])
              fail_line("ir_write_hs", $sformatf("got %b required %b", bus.ir_write, mem_q[0][1]));
            void'(mem_q.pop_front());
          end
        end
      end
      if (bus.ir_write && !(bus.mem_req && bus.mem_ready)) begin
        n_checks++;
        fail_line("ir_write_stray", "ir_write=1 without a completed fetch, required 0");
      end
      if (bus.reg_write && !bus.pc_write) begin
        n_checks++;
        fail_line("reg_write_stray", "reg_write=1 outside retirement, required 0");
      end
      if (bus.state == 3'b111) begin
        if (!mon_in_err) begin
          mon_in_err = 1'b1;
          act = '0; act.err = 1; act.ill = bus.illegal; act.berr = bus.bus_error; act.lat = 16'(mon_cyc);
          sb_check(act, "error_entry");
        end else begin
          n_checks++;
          if (bus.mem_req | bus.ir_write | bus.pc_write | bus.reg_write | bus.mem_we)
            fail_line("error_quiet", "enable asserted in ERROR, required all 0");
        end
      end
      if (bus.pc_write) begin
        act = '0;
        act.ill = bus.illegal; act.berr = bus.bus_error; act.pc_sel = bus.pc_sel;
        act.reg_write = bus.reg_write; act.wb_sel = bus.wb_sel; act.imm = bus.imm_type;
        act.a = ex_a; act.b = ex_b; act.ctrl = ex_ctrl; act.lat = 16'(mon_cyc);
        sb_check(act, "retire");
        ret_cnt++;
        mon_cyc = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int k;
    logic [31:0] ins;
    int fw, mw;
    bus.instr = 32'd0; bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
    @(posedge clk); #1;
    do_reset();
    run_instr(32'h00500093, 1'b0, 0, 0, k);
    run_instr(32'h00000463, 1'b1, 0, 0, k);
    run_instr(32'h00000463, 1'b0, 0, 0, k);
    run_instr(32'h0020A023, 1'b0, 0, 3, k);
    run_instr(32'h0000A183, 1'b0, 2, 2, k);
    run_instr(32'h00500093, 1'b0, TO - 1, 0, k);
    run_instr(32'h0020A023, 1'b0, 0, TO - 1, k);
    run_instr(32'hFFFFFFFF, 1'b0, 1, 0, k);
    do_reset();
    run_timeout(32'd0, 0, 1'b0);
    do_reset();
    run_timeout(32'h0000A183, 1, 1'b1);
    do_reset();
    // abort a JAL in EXECUTE: no retirement may escape the reset
    mem_q.push_back(2'b10);
    bus.instr = {25'd0, OPC_JAL};
    step(1'b1);
    noise_step();
    do_reset();
    for (int i = 0; i < 90; i++) begin
      ins = $urandom;
      ins[6:0] = pick_opc(int'($urandom_range(0, 19)));
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, TO - 1)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, TO - 1)) : int'($urandom_range(0, 3));
      run_instr(ins, 1'($urandom_range(0, 1)), fw, mw, k);
      if (k == 3) do_reset();
    end
    n_checks++;
    if (exp_q.size() != 0) fail_line("sb_drain", $sformatf("%0d events outstanding, required 0", exp_q.size()));
`ifdef RETIRE_COUNT_EN
    n_checks++;
    if (instret != 64'(ret_cnt)) fail_line("instret", $sformatf("got %0d required %0d", instret, ret_cnt));
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle sequencer for the RV32I core. Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the datapath selects, including the format select consumed by the immediate generator. Handshakes with a shared instruction/data memory port through req/ready. Sits between the instruction register and the datapath muxes, register file and memory port.

Parameters:
MEM_TIMEOUT, 15, max cycles mem_req may stay unanswered before bus error (range 1..255).

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-high
instr  in  32  instruction register contents, valid from DECODE onward
mem_ready  in  1  memory port completes the current request this cycle
branch_taken  in  1  branch comparator result, sampled in EXECUTE
ir_write  out  1  load instruction register
pc_write  out  1  update PC; marks instruction retirement
pc_sel  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared
mem_req  out  1  memory request
mem_we  out  1  write request (store)
mem_is_fetch  out  1  request is an instruction fetch
alu_a_sel  out  2  00 rs1, 01 PC, 10 zero
alu_b_sel  out  1  0 rs2, 1 imm
alu_ctrl  out  4  {funct7[5] qualifier, funct3}; 0000 = add
wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4
reg_write  out  1  register file write enable
imm_type  out  3  000 I, 001 S, 010 B, 011 U, 100 J, 111 none
state  out  3  000 FETCH, 001 DECODE, 010 EXECUTE, 011 MEM, 100 WRITEBACK, 111 ERROR
illegal  out  1  sticky, unsupported opcode decoded
bus_error  out  1  sticky, memory timeout

Behaviour:
- Reset (async): state=FETCH, timeout counter=0, illegal=bus_error=0, all other outputs 0 except imm_type=111. Reset mid-instruction aborts with no pc_write/reg_write.
- Outputs are Moore from state and registered decode, except ir_write, and the MEM-exit pc_write, which are qualified by mem_ready in the same cycle.
- FETCH: mem_req=1, mem_is_fetch=1, mem_we=0. On mem_ready: ir_write=1, go to DECODE. Otherwise counter increments.
- Timeout: counter clears on entry to FETCH/MEM. If the counter reaches MEM_TIMEOUT without mem_ready, go to ERROR and set bus_error. mem_ready in the same cycle as the limit wins.
- DECODE: 1 cycle. Decode opcode instr[6:0] into imm_type:
  - 0010011/0000011/1100111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111/0010111 -> U
  - 1101111 -> J
  - 0110011 -> none
  - Any other opcode -> ERROR, set illegal.
  - imm_type is registered and held through the end of the instruction.
- EXECUTE: 1 cycle.
  - OP: a=rs1, b=rs2, alu_ctrl={instr[30],funct3}; go to WRITEBACK.
  - OP-IMM: b=imm, alu_ctrl={instr[30] only if funct3=101, else 0, funct3}; go to WRITEBACK.
  - LUI: a=zero, b=imm, add; go to WRITEBACK.
  - AUIPC: a=PC, b=imm, add; go to WRITEBACK.
  - LOAD/STORE: a=rs1, b=imm, add; go to MEM.
  - BRANCH: pc_write=1, pc_sel=branch_taken?01:00; go to FETCH.
  - JAL: pc_write=1, pc_sel=01, reg_write=1, wb_sel=10; go to FETCH.
  - JALR: a=rs1, b=imm, add, pc_write=1, pc_sel=10, reg_write=1, wb_sel=10; go to FETCH.
- MEM: mem_req=1, mem_we=store, mem_is_fetch=0, ALU selects held.
  - Store with mem_ready: pc_write=1, pc_sel=00; go to FETCH.
  - Load with mem_ready: go to WRITEBACK.
- WRITEBACK: 1 cycle. reg_write=1, wb_sel=01 for load else 00, pc_write=1, pc_sel=00; go to FETCH.
- ERROR: terminal until reset. All enables 0, mem_req=0.
- mem_ready outside FETCH/MEM is ignored.
- Latency with zero-wait memory:
  - branch/JAL/JALR: 3 cycles
  - ALU/LUI/AUIPC: 4 cycles
  - store: 4 cycles
  - load: 5 cycles

Optional Feature:
RETIRE_COUNT_EN:
- Defined: adds output port instret (out, 64). It is reset to 0 and increments on every cycle pc_write=1.
- Not defined: the port is absent and there is no counter logic.

Test Plan:
- instr=0x00500093 (addi x1,x0,5), mem_ready=1 always:
  - states FETCH, DECODE, EXECUTE, WRITEBACK
  - imm_type=000, alu_b_sel=1, alu_ctrl=0000
  - reg_write=1 and pc_write=1 with pc_sel=00 in cycle 4
- instr=0x00000463 (beq x0,x0,8):
  - branch_taken=1: pc_sel=01 in EXECUTE, imm_type=010, cycle 3, no reg_write.
  - Repeat with branch_taken=0: pc_sel=00.
- instr=0x0020A023 (sw), mem_ready low 3 cycles in MEM: mem_req=1, mem_we=1 held; pc_write only in the ready cycle; reg_write never asserted.
- instr=0x0000A183 (lw), 2 wait cycles in FETCH and MEM: ir_write only on the ready cycle; WRITEBACK wb_sel=01, reg_write=1.
- instr=0xFFFFFFFF: DECODE goes to ERROR, illegal=1, no further mem_req. Async rst mid-ERROR returns to FETCH with flags cleared.
- mem_ready held 0 in FETCH: bus_error=1 and state=111 exactly MEM_TIMEOUT=15 cycles after request start. A variant with ready on cycle 15 completes normally.
